rc4_crack_arbiter: RTL

//  Parametrised coordinator for NUM_CORES RC4 key-search cores.
//  - Partitions the 2^SEARCH_W keyspace into equal per-core ranges.
//  - Launches all cores together, then latches the first valid key reported (lowest index wins ties).
//  - Halts every core once a key is latched, and reports a not-found result when all cores are exhausted.
//  - Sits between the cracker cores and the HEX display decoders.

---
 rtl/rc4_crack_arbiter_if.sv | 36 +++
 rtl/rc4_crack_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rc4_crack_arbiter_if.sv
// Bundle of start/abort control, per-core search handshake and result signals
// between the RC4 crack coordinator and its environment.
interface rc4_crack_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                       start;
  logic                       abort;
  logic [NUM_CORES-1:0]       core_found;
  logic [NUM_CORES-1:0]       core_exhausted;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0]       core_halt;
  logic [NUM_CORES*KEY_W-1:0] core_base;
  logic [NUM_CORES*KEY_W-1:0] core_limit;
  logic [KEY_W-1:0]           key_out;
  logic                       key_valid;
  logic [IDX_W-1:0]           winner_idx;
  logic                       busy;
  logic                       not_found;
  logic [31:0]                elapsed;

  modport master (
    output start, abort, core_found, core_exhausted, core_key,
    input  core_start, core_halt, core_base, core_limit,
           key_out, key_valid, winner_idx, busy, not_found, elapsed
  );

  modport slave (
    input  start, abort, core_found, core_exhausted, core_key,
    output core_start, core_halt, core_base, core_limit,
           key_out, key_valid, winner_idx, busy, not_found, elapsed
  );
endinterface

// File: rtl/rc4_crack_arbiter.sv
// Coordinates NUM_CORES RC4 key-search cores: fixed keyspace split, launch, first-hit latch.
// Define SEARCH_TIMER_EN to build the saturating RUN-cycle counter on `elapsed`.
module rc4_crack_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24,
  parameter int SEARCH_W  = 22
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rc4_crack_arbiter_if.slave   bus
);
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int SPAN_LOG = SEARCH_W - $clog2(NUM_CORES);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_FOUND, S_EXHAUST} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     first_idx;
  logic [KEY_W-1:0]     first_key;
  logic                 any_found;

  // Each range is a power-of-two block, so base/limit are pure constants.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_range
    localparam logic [KEY_W-1:0] BASE    = KEY_W'(g) << SPAN_LOG;
    localparam logic [KEY_W-1:0] SPAN_M1 = (KEY_W'(1) << SPAN_LOG) - KEY_W'(1);
    assign bus.core_base [g*KEY_W +: KEY_W] = BASE;
    assign bus.core_limit[g*KEY_W +: KEY_W] = BASE + SPAN_M1;
  end

  assign any_found = |bus.core_found;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    first_idx = '0;
    first_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_found[i]) begin
        first_idx = IDX_W'(i);
        first_key = bus.core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      key_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      key_q    <= key_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    key_d    = key_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUST: begin
        if (bus.start) begin
          state_d = S_LAUNCH;
          mask_d  = '0;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        mask_d = mask_q | bus.core_exhausted;
        // abort beats a hit, and a hit beats exhaustion in the same cycle
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (any_found) begin
          state_d  = S_FOUND;
          key_d    = first_key;
          winner_d = first_idx;
        end else if (mask_d == '1) begin
          state_d = S_EXHAUST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.core_start = '0;
    bus.core_halt  = '1;
    bus.busy       = 1'b0;
    bus.key_valid  = 1'b0;
    bus.not_found  = 1'b0;
    case (state_q)
      S_LAUNCH: begin
        bus.core_start = '1;
        bus.core_halt  = '0;
        bus.busy       = 1'b1;
      end
      S_RUN: begin
        bus.core_halt = '0;
        bus.busy      = 1'b1;
      end
      S_FOUND:   bus.key_valid = 1'b1;
      S_EXHAUST: bus.not_found = 1'b1;
      default: ;
    endcase
  end

  assign bus.key_out    = key_q;
  assign bus.winner_idx = winner_q;

`ifdef SEARCH_TIMER_EN
  logic [31:0] elapsed_q, elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (state_q == S_LAUNCH)
      elapsed_d = '0;
    else if (state_q == S_RUN && elapsed_q != 32'hFFFF_FFFF)
      elapsed_d = elapsed_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) elapsed_q <= '0;
    else          elapsed_q <= elapsed_d;
  end

  assign bus.elapsed = elapsed_q;
`else
  assign bus.elapsed = '0;
`endif
endmodule
